// File: rtl/motor_mix_pkg.sv
// Shared types and helpers for the motor mixing sequencer: FSM states,
// generator axis codes and the accumulator clamp.
package motor_mix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PITCH,
    ST_ROLL,
    ST_YAW,
    ST_DONE
  } state_t;

  localparam logic [1:0] AXIS_PITCH = 2'd0;
  localparam logic [1:0] AXIS_ROLL  = 2'd1;
  localparam logic [1:0] AXIS_YAW   = 2'd2;
  localparam logic [1:0] AXIS_NONE  = 2'd3;

  // Clamp a sign-extended accumulator into [lo, hi].
  function automatic logic signed [31:0] sat_clamp(input logic signed [31:0] acc,
                                                   input logic signed [31:0] lo,
                                                   input logic signed [31:0] hi);
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/mix_saturate.sv
// Combinational clamp of one signed motor accumulator to a motor command.
module mix_saturate
  import motor_mix_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 11,
  parameter int MOTOR_MAX = 255,
  parameter int MOTOR_MIN = 0
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  output logic        [DATA_W-1:0] o_cmd
);

  logic signed [31:0] w_acc32;

  assign w_acc32 = 32'(i_acc);
  assign o_cmd   = DATA_W'(sat_clamp(w_acc32, 32'(MOTOR_MIN), 32'(MOTOR_MAX)));

endmodule

// File: rtl/motor_mix_sequencer.sv
// Sequences one shared offset generator over pitch/roll/yaw, accumulates the
// per-motor offsets on top of throttle and publishes saturated motor commands.
module motor_mix_sequencer
  import motor_mix_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 11,
  parameter int MOTOR_MAX = 255,
  parameter int MOTOR_MIN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              rec_valid,
  input  logic [DATA_W-1:0] throttle_rec_val,
  input  logic [DATA_W-1:0] pitch_rec_val,
  input  logic [DATA_W-1:0] roll_rec_val,
  input  logic [DATA_W-1:0] yaw_rec_val,
  output logic [1:0]        gen_axis,
  output logic [DATA_W-1:0] gen_val,
  input  logic [DATA_W-1:0] gen_m1_offset,
  input  logic [DATA_W-1:0] gen_m2_offset,
  input  logic [DATA_W-1:0] gen_m3_offset,
  input  logic [DATA_W-1:0] gen_m4_offset,
  output logic [DATA_W-1:0] motor_1_cmd,
  output logic [DATA_W-1:0] motor_2_cmd,
  output logic [DATA_W-1:0] motor_3_cmd,
  output logic [DATA_W-1:0] motor_4_cmd,
  output logic              motor_upd,
  output logic              busy,
  output logic              rec_drop
);

  localparam logic [DATA_W-1:0] L_MIN = DATA_W'(MOTOR_MIN);

  state_t r_state;
  state_t w_next;

  logic        [DATA_W-1:0] r_pitch;
  logic        [DATA_W-1:0] r_roll;
  logic        [DATA_W-1:0] r_yaw;
  logic signed [ACC_W-1:0]  r_acc     [4];
  logic        [DATA_W-1:0] r_cmd     [4];
  logic                     r_upd;
  logic                     r_drop;

  logic        [DATA_W-1:0] w_off     [4];
  logic signed [ACC_W-1:0]  w_off_ext [4];
  logic        [DATA_W-1:0] w_sat     [4];
  logic                     w_any_active;

  assign w_off[0] = gen_m1_offset;
  assign w_off[1] = gen_m2_offset;
  assign w_off[2] = gen_m3_offset;
  assign w_off[3] = gen_m4_offset;

  always_comb begin
    w_any_active = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_off_ext[i] = ACC_W'($signed(w_off[i]));
      if (r_cmd[i] != L_MIN) w_any_active = 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_sat
      mix_saturate #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .MOTOR_MAX(MOTOR_MAX),
        .MOTOR_MIN(MOTOR_MIN)
      ) u_sat (
        .i_acc(r_acc[g]),
        .o_cmd(w_sat[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    gen_axis = AXIS_NONE;
    gen_val  = '0;
    case (r_state)
      ST_IDLE:  if (rec_valid) w_next = ST_PITCH;
      ST_PITCH: begin
        w_next   = ST_ROLL;
        gen_axis = AXIS_PITCH;
        gen_val  = r_pitch;
      end
      ST_ROLL: begin
        w_next   = ST_YAW;
        gen_axis = AXIS_ROLL;
        gen_val  = r_roll;
      end
      ST_YAW: begin
        w_next   = ST_DONE;
        gen_axis = AXIS_YAW;
        gen_val  = r_yaw;
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (!arm) w_next = ST_IDLE;
  end

  // Disarm overrides everything: commands drop to MOTOR_MIN and any partial sum is abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pitch <= '0;
      r_roll  <= '0;
      r_yaw   <= '0;
      r_upd   <= 1'b0;
      r_drop  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_acc[i] <= '0;
        r_cmd[i] <= L_MIN;
      end
    end else begin
      r_upd  <= 1'b0;
      r_drop <= rec_valid && (r_state != ST_IDLE);
      if (!arm) begin
        for (int unsigned i = 0; i < 4; i++) r_cmd[i] <= L_MIN;
        r_upd <= w_any_active;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (rec_valid) begin
              r_pitch <= pitch_rec_val;
              r_roll  <= roll_rec_val;
              r_yaw   <= yaw_rec_val;
              for (int unsigned i = 0; i < 4; i++) r_acc[i] <= ACC_W'(throttle_rec_val);
            end
          end
          ST_PITCH, ST_ROLL, ST_YAW: begin
            for (int unsigned i = 0; i < 4; i++) r_acc[i] <= r_acc[i] + w_off_ext[i];
          end
          ST_DONE: begin
            for (int unsigned i = 0; i < 4; i++) r_cmd[i] <= w_sat[i];
            r_upd <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign motor_1_cmd = r_cmd[0];
  assign motor_2_cmd = r_cmd[1];
  assign motor_3_cmd = r_cmd[2];
  assign motor_4_cmd = r_cmd[3];
  assign motor_upd   = r_upd;
  assign rec_drop    = r_drop;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_motor_mix_sequencer.sv
// Self-checking bench for motor_mix_sequencer with a behavioural generator
// and a transaction-level reference model.
module tb_motor_mix_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm;
  logic       rec_valid;
  logic [7:0] throttle_rec_val, pitch_rec_val, roll_rec_val, yaw_rec_val;
  logic [1:0] gen_axis;
  logic [7:0] gen_val;
  logic [7:0] g1, g2, g3, g4;
  logic [7:0] motor_1_cmd, motor_2_cmd, motor_3_cmd, motor_4_cmd;
  logic       motor_upd, busy, rec_drop;
  logic [7:0] mc [4];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  motor_mix_sequencer #(
    .DATA_W(8), .ACC_W(11), .MOTOR_MAX(255), .MOTOR_MIN(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .rec_valid(rec_valid),
    .throttle_rec_val(throttle_rec_val), .pitch_rec_val(pitch_rec_val),
    .roll_rec_val(roll_rec_val), .yaw_rec_val(yaw_rec_val),
    .gen_axis(gen_axis), .gen_val(gen_val),
    .gen_m1_offset(g1), .gen_m2_offset(g2), .gen_m3_offset(g3), .gen_m4_offset(g4),
    .motor_1_cmd(motor_1_cmd), .motor_2_cmd(motor_2_cmd),
    .motor_3_cmd(motor_3_cmd), .motor_4_cmd(motor_4_cmd),
    .motor_upd(motor_upd), .busy(busy), .rec_drop(rec_drop)
  );

  assign mc[0] = motor_1_cmd;
  assign mc[1] = motor_2_cmd;
  assign mc[2] = motor_3_cmd;
  assign mc[3] = motor_4_cmd;

  // Shared offset generator: +v / -v per motor depending on axis.
  always_comb begin
    g1 = 8'd0; g2 = 8'd0; g3 = 8'd0; g4 = 8'd0;
    case (gen_axis)
      2'd0: begin g1 = gen_val;  g2 = gen_val;  g3 = -gen_val; g4 = -gen_val; end
      2'd1: begin g1 = gen_val;  g2 = -gen_val; g3 = gen_val;  g4 = -gen_val; end
      2'd2: begin g1 = gen_val;  g2 = -gen_val; g3 = -gen_val; g4 = gen_val;  end
      default: ;
    endcase
  end

  // Reference model state: phase 0 idle, 1..3 axis cycles, 4 publish cycle.
  int m_ph;
  int m_cmd  [4];
  int m_pend [4];
  int m_lat  [3];
  bit m_upd, m_drop;
  int SG [3][4] = '{'{1, 1, -1, -1}, '{1, -1, 1, -1}, '{1, -1, -1, 1}};

  function automatic int s8(input int x);
    int y;
    y = x & 255;
    return (y >= 128) ? y - 256 : y;
  endfunction

  function automatic int mix_result(input int m, input int t, input int p, input int r, input int y);
    int v[3];
    int sum;
    v[0] = p; v[1] = r; v[2] = y;
    sum = t;
    for (int a = 0; a < 3; a++) sum += (SG[a][m] > 0) ? s8(v[a]) : s8(-v[a]);
    if (sum > 255) sum = 255;
    if (sum < 0)   sum = 0;
    return sum;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_upd = 0; m_drop = 0;
    for (int i = 0; i < 4; i++) begin m_cmd[i] = 0; m_pend[i] = 0; end
    for (int i = 0; i < 3; i++) m_lat[i] = 0;
  endtask

  // Drives one clock cycle of inputs, advances the model, returns at posedge+1.
  task automatic cycle(input bit a, input bit rv, input int t, input int p, input int r, input int y);
    bit any;
    arm = a; rec_valid = rv;
    throttle_rec_val = 8'(t); pitch_rec_val = 8'(p); roll_rec_val = 8'(r); yaw_rec_val = 8'(y);
    m_drop = rv && (m_ph != 0);
    m_upd  = 0;
    if (!a) begin
      any = 0;
      for (int i = 0; i < 4; i++) if (m_cmd[i] != 0) any = 1;
      m_upd = any;
      for (int i = 0; i < 4; i++) m_cmd[i] = 0;
      m_ph = 0;
    end else if (m_ph == 0) begin
      if (rv) begin
        for (int i = 0; i < 4; i++) m_pend[i] = mix_result(i, t & 255, p & 255, r & 255, y & 255);
        m_lat[0] = p & 255; m_lat[1] = r & 255; m_lat[2] = y & 255;
        m_ph = 1;
      end
    end else if (m_ph == 4) begin
      for (int i = 0; i < 4; i++) m_cmd[i] = m_pend[i];
      m_upd = 1;
      m_ph  = 0;
    end else begin
      m_ph++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arm = 1'b0; rec_valid = 1'b0;
    throttle_rec_val = '0; pitch_rec_val = '0; roll_rec_val = '0; yaw_rec_val = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mc[i] !== 8'd0) begin n_err++; $display("FAIL reset_cmd%0d: got %0d expected 0", i + 1, mc[i]); end
    end
    n_checks++;
    if ({motor_upd, busy, rec_drop} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got upd/busy/drop=%b expected 000", {motor_upd, busy, rec_drop});
    end
    n_checks++;
    if (gen_axis !== 2'd3 || gen_val !== 8'd0) begin
      n_err++; $display("FAIL reset_gen: got axis=%0d val=%0d expected 3/0", gen_axis, gen_val);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_mix();
    int exp_c [4] = '{110, 110, 90, 90};
    cycle(1, 1, 100, 10, 0, 0);
    n_checks++;
    if (busy !== 1'b1 || gen_axis !== 2'd0 || gen_val !== 8'd10) begin
      n_err++; $display("FAIL basic_pitch: got busy=%b axis=%0d val=%0d expected 1/0/10", busy, gen_axis, gen_val);
    end
    for (int k = 1; k <= 4; k++) begin
      cycle(1, 0, 0, 0, 0, 0);
      if (k < 4) begin
        n_checks++;
        if (motor_upd !== 1'b0) begin n_err++; $display("FAIL basic_early_upd: cycle %0d got 1 expected 0", k + 1); end
      end
    end
    n_checks++;
    if (motor_upd !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_upd: got upd=%b busy=%b expected 1/0", motor_upd, busy);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mc[i] !== 8'(exp_c[i])) begin n_err++; $display("FAIL basic_cmd%0d: got %0d expected %0d", i + 1, mc[i], exp_c[i]); end
    end
  endtask

  task automatic test_saturation();
    int exp_a [4] = '{255, 230, 230, 230};
    int exp_b [4] = '{25, 25, 0, 0};
    cycle(1, 1, 250, 20, 20, 20);
    repeat (4) cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mc[i] !== 8'(exp_a[i])) begin n_err++; $display("FAIL sat_high_cmd%0d: got %0d expected %0d", i + 1, mc[i], exp_a[i]); end
    end
    cycle(1, 1, 5, 20, 0, 0);
    repeat (4) cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mc[i] !== 8'(exp_b[i])) begin n_err++; $display("FAIL sat_low_cmd%0d: got %0d expected %0d", i + 1, mc[i], exp_b[i]); end
    end
  endtask

  task automatic test_overrun();
    int exp_c [4] = '{80, 20, 80, 20};
    cycle(1, 1, 50, 0, 30, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 200, 100, 100, 100);
    n_checks++;
    if (rec_drop !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL overrun_drop: got drop=%b busy=%b expected 1/1", rec_drop, busy);
    end
    cycle(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (rec_drop !== 1'b0) begin n_err++; $display("FAIL overrun_drop_len: got 1 expected 0"); end
    cycle(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (motor_upd !== 1'b1) begin n_err++; $display("FAIL overrun_upd: got 0 expected 1"); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mc[i] !== 8'(exp_c[i])) begin n_err++; $display("FAIL overrun_cmd%0d: got %0d expected %0d", i + 1, mc[i], exp_c[i]); end
    end
    repeat (3) begin
      cycle(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (motor_upd !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL overrun_second_upd: got upd=%b busy=%b expected 0/0", motor_upd, busy);
      end
    end
  endtask

  task automatic test_disarm();
    cycle(1, 1, 120, 40, 40, 40);
    cycle(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (gen_axis !== 2'd1) begin n_err++; $display("FAIL disarm_in_roll: got axis=%0d expected 1", gen_axis); end
    cycle(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (motor_upd !== 1'b1 || busy !== 1'b0 || gen_axis !== 2'd3) begin
      n_err++; $display("FAIL disarm_abort: got upd=%b busy=%b axis=%0d expected 1/0/3", motor_upd, busy, gen_axis);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mc[i] !== 8'd0) begin n_err++; $display("FAIL disarm_cmd%0d: got %0d expected 0", i + 1, mc[i]); end
    end
    cycle(0, 1, 200, 10, 10, 10);
    n_checks++;
    if ({motor_upd, busy, rec_drop} !== 3'b000) begin
      n_err++; $display("FAIL disarm_ignore: got upd/busy/drop=%b expected 000", {motor_upd, busy, rec_drop});
    end
    repeat (6) begin
      cycle(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (motor_upd !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL disarm_stale: got upd=%b busy=%b expected 0/0", motor_upd, busy);
      end
    end
  endtask

  task automatic test_async_reset();
    int exp_c [4] = '{110, 110, 90, 90};
    cycle(1, 1, 200, 5, 5, 5);
    repeat (4) cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 90, 30, 30, 30);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    n_checks++;
    if (gen_axis !== 2'd2 || mc[0] === 8'd0) begin
      n_err++; $display("FAIL areset_setup: got axis=%0d cmd1=%0d expected 2/nonzero", gen_axis, mc[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({motor_upd, busy, rec_drop} !== 3'b000 || gen_axis !== 2'd3 || gen_val !== 8'd0) begin
      n_err++; $display("FAIL areset_flags: got upd/busy/drop=%b axis=%0d val=%0d expected 000/3/0",
                        {motor_upd, busy, rec_drop}, gen_axis, gen_val);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mc[i] !== 8'd0) begin n_err++; $display("FAIL areset_cmd%0d: got %0d expected 0", i + 1, mc[i]); end
    end
    #3 rst_n = 1'b1;
    cycle(1, 1, 100, 10, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cycle(1, 0, 0, 0, 0, 0);
      n_checks++;
      if (motor_upd !== (k == 4)) begin
        n_err++; $display("FAIL areset_latency: cycle %0d got upd=%b expected %b", k + 1, motor_upd, (k == 4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mc[i] !== 8'(exp_c[i])) begin n_err++; $display("FAIL areset_cmd_after%0d: got %0d expected %0d", i + 1, mc[i], exp_c[i]); end
    end
  endtask

  task automatic test_random();
    int exp_axis, exp_val;
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 15) != 0), ($urandom_range(0, 2) == 0),
            $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255));
      exp_axis = (m_ph >= 1 && m_ph <= 3) ? m_ph - 1 : 3;
      exp_val  = (m_ph >= 1 && m_ph <= 3) ? m_lat[m_ph - 1] : 0;
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (mc[i] !== 8'(m_cmd[i])) begin
          n_err++; $display("FAIL rand_cmd%0d @%0d: got %0d expected %0d", i + 1, n, mc[i], m_cmd[i]);
        end
      end
      n_checks++;
      if (motor_upd !== m_upd || rec_drop !== m_drop || busy !== (m_ph != 0)) begin
        n_err++; $display("FAIL rand_flags @%0d: got upd/drop/busy=%b%b%b expected %b%b%b",
                          n, motor_upd, rec_drop, busy, m_upd, m_drop, (m_ph != 0));
      end
      n_checks++;
      if (gen_axis !== 2'(exp_axis) || gen_val !== 8'(exp_val)) begin
        n_err++; $display("FAIL rand_gen @%0d: got axis=%0d val=%0d expected %0d/%0d",
                          n, gen_axis, gen_val, exp_axis, exp_val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_mix();
    test_saturation();
    test_overrun();
    test_disarm();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
